// File: rtl/svf_ctrl.sv
// Sequencer and configurator for a shared 8-bit Chamberlin SVF: sample-rate divider,
// between-sample coefficient updates with cutoff slewing, and a saturating tap mixer.
module svf_ctrl #(
    parameter int CLK_DIV = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [4:0] cfg_cutoff,
    input  logic [3:0] cfg_res,
    input  logic [2:0] cfg_mode,
    input  logic [7:0] audio_in,
    output logic [7:0] svf_in,
    output logic       svf_sample_valid,
    output logic [4:0] alpha1,
    output logic [3:0] alpha2,
    input  logic [7:0] svf_hp,
    input  logic [7:0] svf_bp,
    input  logic [7:0] svf_lp,
    output logic [7:0] audio_out,
    output logic       out_valid,
    output logic       ramping
);

    localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        COEF   = 2'd2
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [7:0]       svf_in_r;
    logic             svf_sample_valid_r;
    logic [7:0]       audio_out_r;
    logic             out_valid_r;
    logic [4:0]       alpha1_r;
    logic [4:0]       tgt_r;
    logic [3:0]       alpha2_r;
    logic [2:0]       mode_r;
    logic             pending_r;
    logic [4:0]       pend_cutoff_r;
    logic [3:0]       pend_damp_r;
    logic [2:0]       pend_mode_r;

    logic             tick_s;
    logic             cfg_accept_s;
    logic [7:0]       mix_s;

    // Damping shrinks as resonance rises; floor of 2 keeps the loop stable.
    function automatic logic [3:0] damp_of(input logic [3:0] res);
        if (res > 4'd13) begin
            return 4'd2;
        end else begin
            return 4'd15 - res;
        end
    endfunction

    function automatic logic [7:0] mix(input logic [2:0] mode, input logic [7:0] hp,
                                       input logic [7:0] bp, input logic [7:0] lp,
                                       input logic [7:0] byp);
        logic signed [9:0] sum;
        sum = 10'sd0;
        if (mode == 3'b000) begin
            return byp;
        end
        if (mode[0]) sum = sum + $signed({{2{lp[7]}}, lp});
        if (mode[1]) sum = sum + $signed({{2{bp[7]}}, bp});
        if (mode[2]) sum = sum + $signed({{2{hp[7]}}, hp});
        if (sum > 10'sd127) begin
            return 8'h7F;
        end else if (sum < -10'sd128) begin
            return 8'h80;
        end else begin
            return sum[7:0];
        end
    endfunction

    assign tick_s       = (cnt_r == CNT_W'(CLK_DIV - 1));
    assign cfg_accept_s = cfg_valid & ~pending_r;

    // Tap mixer feeding the output register.
    always_comb begin
        mix_s = mix(mode_r, svf_hp, svf_bp, svf_lp, svf_in_r);
    end

    // Sample-period divider.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (tick_s) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    // Sequencer FSM, config capture and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r            <= IDLE;
            svf_in_r           <= 8'd0;
            svf_sample_valid_r <= 1'b0;
            audio_out_r        <= 8'd0;
            out_valid_r        <= 1'b0;
            alpha1_r           <= 5'd0;
            tgt_r              <= 5'd0;
            alpha2_r           <= 4'd15;
            mode_r             <= 3'b001;
            pending_r          <= 1'b0;
            pend_cutoff_r      <= 5'd0;
            pend_damp_r        <= 4'd15;
            pend_mode_r        <= 3'b001;
        end else begin
            svf_sample_valid_r <= 1'b0;
            out_valid_r        <= 1'b0;
            // Accepting only while nothing is pending means the COEF apply below never collides.
            if (cfg_accept_s) begin
                pending_r     <= 1'b1;
                pend_cutoff_r <= cfg_cutoff;
                pend_damp_r   <= damp_of(cfg_res);
                pend_mode_r   <= cfg_mode;
            end
            case (state_r)
                IDLE: begin
                    if (tick_s) begin
                        svf_in_r           <= audio_in;
                        svf_sample_valid_r <= 1'b1;
                        state_r            <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    audio_out_r <= mix_s;
                    out_valid_r <= 1'b1;
                    state_r     <= COEF;
                end
                COEF: begin
                    if (alpha1_r < tgt_r) begin
                        alpha1_r <= alpha1_r + 5'd1;
                    end else if (alpha1_r > tgt_r) begin
                        alpha1_r <= alpha1_r - 5'd1;
                    end
                    if (pending_r) begin
                        tgt_r     <= pend_cutoff_r;
                        alpha2_r  <= pend_damp_r;
                        mode_r    <= pend_mode_r;
                        pending_r <= 1'b0;
                    end
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign cfg_ready        = ~pending_r;
    assign svf_in           = svf_in_r;
    assign svf_sample_valid = svf_sample_valid_r;
    assign alpha1           = alpha1_r;
    assign alpha2           = alpha2_r;
    assign audio_out        = audio_out_r;
    assign out_valid        = out_valid_r;
    assign ramping          = (alpha1_r != tgt_r);

endmodule
